// File: rtl/logic_slice_unit_pkg.sv
// logic_pkg: op encodings and FSM states shared by the slice-serial logic unit
package logic_pkg;
  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOR = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} lsu_state_t;
endpackage

// File: rtl/logic_slice_unit_slice.sv
// logic_slice: one SLICE-wide bitwise AND/OR/XOR/NOR lane
module logic_slice import logic_pkg::*; #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] z
);
  assign z = op == LOP_AND ? x & y :
             op == LOP_OR  ? x | y :
             op == LOP_XOR ? x ^ y : ~(x | y);
endmodule

// File: rtl/logic_slice_unit.sv
// logic_slice_unit: slice-serial bitwise logic unit with valid/ready handshake and zero flag
module logic_slice_unit import logic_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  lsu_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_zero;
  logic [BW-1:0]    w_base;
  logic [SLICE-1:0] w_z;
  logic             w_last;
  assign w_base    = BW'(r_cnt * SLICE);
  assign w_last    = r_cnt == CW'(NSLICE - 1);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign res       = r_res;
  assign zero      = r_zero;
  logic_slice #(.SLICE(SLICE)) u_slice (
    .x  (r_a[w_base +: SLICE]),
    .y  (r_b[w_base +: SLICE]),
    .op (r_op),
    .z  (w_z)
  );
  always_comb begin
    w_next = r_state;
    w_res = r_res;
    w_res[w_base +: SLICE] = w_z;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= LOP_AND;
      r_cnt   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_op  <= op;
        r_cnt <= '0;
      end
      if (r_state == RUN) begin
        r_res <= w_res;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_zero <= ~|w_res;
      end
    end
  end
endmodule

// File: tb/tb_logic_slice_unit.sv
// tb_logic_slice_unit: four parameterisations driven in lockstep against a whole-word reference model
module tb_logic_slice_unit;
  import logic_pkg::*;
  localparam int NS [4] = '{4, 32, 1, 4};
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [31:0] a = 0, b = 0;
  logic [1:0] op = 0;
  wire [3:0] rdy, vld, zr;
  wire [31:0] rs0, rs1, rs2;
  wire [15:0] rs3;
  logic [31:0] rs [4];
  int n_tests = 0, n_fail = 0;
  int phase [4] = '{default: 0};
  int left [4] = '{default: 0};
  logic [31:0] pend [4] = '{default: 0};
  logic [31:0] exp_res [4] = '{default: 0};
  logic exp_zero [4] = '{default: 0};
  always #5 clk = ~clk;
  assign rs[0] = rs0;
  assign rs[1] = rs1;
  assign rs[2] = rs2;
  assign rs[3] = {16'h0, rs3};
  logic_slice_unit #(.WIDTH(32), .SLICE(8)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .b(b), .op(op), .out_valid(vld[0]), .out_ready(out_ready), .res(rs0), .zero(zr[0]));
  logic_slice_unit #(.WIDTH(32), .SLICE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .b(b), .op(op), .out_valid(vld[1]), .out_ready(out_ready), .res(rs1), .zero(zr[1]));
  logic_slice_unit #(.WIDTH(32), .SLICE(32)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .b(b), .op(op), .out_valid(vld[2]), .out_ready(out_ready), .res(rs2), .zero(zr[2]));
  logic_slice_unit #(.WIDTH(16), .SLICE(4)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(vld[3]), .out_ready(out_ready), .res(rs3), .zero(zr[3]));
  function automatic logic [31:0] lop(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      LOP_AND: return x & y;
      LOP_OR:  return x | y;
      LOP_XOR: return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // phase: 0 idle, 1 computing (left = cycles still to go), 2 result presented
  always @(posedge clk or negedge rst_n)
    for (int j = 0; j < 4; j++)
      if (!rst_n) begin
        phase[j] = 0;
        exp_res[j] = 0;
        exp_zero[j] = 0;
      end else if (phase[j] == 0 && in_valid) begin
        phase[j] = 1;
        left[j] = NS[j];
        pend[j] = lop(op, a, b) & (j == 3 ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      end else if (phase[j] == 1) begin
        left[j]--;
        if (left[j] == 0) begin
          phase[j] = 2;
          exp_res[j] = pend[j];
          exp_zero[j] = pend[j] == 0;
        end
      end else if (phase[j] == 2 && out_ready) phase[j] = 0;
  always @(negedge clk)
    for (int j = 0; j < 4; j++) begin
      check($sformatf("in_ready[%0d]", j), rdy[j], phase[j] == 0);
      check($sformatf("out_valid[%0d]", j), vld[j], phase[j] == 2);
      if (phase[j] == 2) begin
        check($sformatf("res[%0d]", j), rs[j], exp_res[j]);
        check($sformatf("zero[%0d]", j), zr[j], exp_zero[j]);
      end
    end
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] to,
                        input logic [31:0] lit, input bit rnd, input bit chg);
    int lat = 0;
    a = ta; b = tb; op = to; in_valid = 1;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 0;
      if (chg) a = 32'hFFFF_FFFF;
      if (rnd) out_ready = 1'($urandom);
    end while (!vld[0] && lat < 60);
    check("latency", 32'(lat - 1), 4);
    if (!rnd) begin
      check("model_pin", exp_res[0], lit);
      check("res_pin", rs[0], lit);
      check("zero_pin", zr[0], lit == 0);
    end
    lat = 0;
    while (rdy != 4'hF && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!rnd && lat == 1) check("single_valid", vld[0], 0);
      if (rnd) out_ready = 1'($urandom);
    end
    check("drain", rdy, 4'hF);
    out_ready = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("rst_res", rs[0], 0);
    check("rst_zero", zr[0], 0);
    check("rst_valid", vld, 0);
    check("rst_ready", rdy, 4'hF);
    run_op(32'hF0F0_1234, 32'h0F0F_0000, LOP_OR, 32'hFFFF_1234, 0, 0);
    run_op(32'hAAAA_AAAA, 32'hFFFF_0000, LOP_AND, 32'hAAAA_0000, 0, 0);
    run_op(32'hAAAA_AAAA, 32'hFFFF_0000, LOP_OR, 32'hFFFF_AAAA, 0, 0);
    run_op(32'hAAAA_AAAA, 32'hFFFF_0000, LOP_XOR, 32'h5555_AAAA, 0, 0);
    run_op(32'hAAAA_AAAA, 32'hFFFF_0000, LOP_NOR, 32'h0000_5555, 0, 0);
    out_ready = 0; a = 0; b = 0; op = LOP_AND; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (35) @(negedge clk);
    check("bp_valid", vld, 4'hF);
    check("bp_res", rs[0], 0);
    check("bp_zero", zr[0], 1);
    repeat (5) begin
      in_valid = 1;
      a = $urandom;
      @(negedge clk);
      check("bp_hold", vld[0], 1);
      check("bp_ready", rdy[0], 0);
    end
    check("bp_res_held", rs[0], 0);
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    check("bp_release", rdy, 4'hF);
    run_op(32'h0000_00FF, 32'h0F0F_0F0F, LOP_AND, 32'h0000_000F, 0, 1);
    a = 32'h1234_5678; b = 32'h8765_4321; op = LOP_OR; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", vld, 0);
    check("mid_rst_res0", rs[0], 0);
    check("mid_rst_res1", rs[1], 0);
    check("mid_rst_zero", zr[0], 0);
    @(negedge clk);
    rst_n = 1;
    check("mid_rst_ready", rdy, 4'hF);
    run_op(32'h1, 32'h2, LOP_XOR, 32'h3, 0, 0);
    repeat (30) run_op($urandom, $urandom, 2'($urandom), 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_slice_unit.md
# logic_slice_unit

- Parametrised, slice-serial bitwise logic unit: successor to the fixed 32-bit combinational OR.
- Computes AND, OR, XOR or NOR of two WIDTH-bit operands, SLICE bits per clock, LSB slice first.
- Uses a valid/ready handshake on both sides and produces a zero flag.
- Sits beside the ALU and serves multi-cycle or area-constrained datapaths where one narrow slice of logic is reused across the word.

## Interface

Parameters:

- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per cycle; 1 <= SLICE <= WIDTH
- NSLICE, WIDTH/SLICE (derived, not overridable), cycles per operation

Ports:

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  unit can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- out_valid  out  1  res/zero valid
- out_ready  in  1  consumer accepts result
- res  out  WIDTH  result word
- zero  out  1  res == 0

One clock; reset is asynchronous and active-low.

## Operation

States:

- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready, latch a, b, op, clear slice counter, go RUN.
- RUN:
  - in_ready=0.
  - In run cycle i (0..NSLICE-1), write res[i*SLICE +: SLICE] = op(a_q, b_q) on that slice.
  - After slice NSLICE-1, go DONE.
- DONE:
  - out_valid=1; res and zero held stable.
  - On out_ready, go IDLE.
  - out_valid and res must not change while out_ready=0.

Rules:

- NOR is the bitwise ~(a|b) per slice, never a whole-word inversion.
- Operands and op are captured at acceptance. Changes on a/b/op after acceptance have no effect.
- in_valid while not IDLE is ignored; there is no queueing.
- zero = ~|res, registered together with the final slice. It is valid only while out_valid.
- Counter width is $clog2(NSLICE), minimum 1 bit. It wraps to 0 on entry to RUN and is never read in IDLE/DONE.
- Slices not yet written in RUN hold the previous result. The consumer sees res only in DONE.
- Reset (any state, including mid-RUN or DONE awaiting out_ready):
  - Abort immediately to IDLE.
  - res=0, zero=0, out_valid=0, in_ready=1 once rst_n deasserted, counter=0.
  - A partial operation is discarded.

## Timing

- Acceptance at edge k.
- Slice i written at edge k+1+i.
- out_valid rises after edge k+NSLICE. Latency is NSLICE cycles from acceptance to out_valid.
- SLICE==WIDTH: single RUN cycle, latency 1.
- DONE with out_ready already high leaves at the next edge: out_valid is high for exactly 1 cycle, and in_ready returns the cycle after.
- Minimum issue interval: NSLICE+2 cycles.
- in_ready is a pure function of state (no combinational path from in_valid). out_valid is registered state.
- Reset is asynchronous assert and synchronous-safe deassert. The first acceptance is possible on the first edge with rst_n=1.

## Structure

- Shared package logic_pkg holds:
  - op encoding constants LOP_AND=2'b00, LOP_OR=2'b01, LOP_XOR=2'b10, LOP_NOR=2'b11
  - state typedef lsu_state_t {IDLE, RUN, DONE}
- Sub-module logic_slice: combinational, SLICE-wide; inputs x, y, op; output z. It is instantiated once and fed the current slice via indexed part-select (counter*SLICE).
- Top holds the FSM, operand/op registers, counter, result register and zero flag.

## Test plan

1. WIDTH=32, SLICE=8, a=0xF0F0_1234, b=0x0F0F_0000, op=OR, out_ready=1 -> out_valid 4 cycles after acceptance, res=0xFFFF_1234, zero=0, single out_valid cycle.
2. All ops on a=0xAAAA_AAAA, b=0xFFFF_0000 -> AND 0xAAAA_0000, OR 0xFFFF_AAAA, XOR 0x5555_AAAA, NOR 0x0000_5555.
3. Backpressure: a=b=0, op=AND, out_ready low 5 cycles -> out_valid held, res=0, zero=1; new in_valid ignored (in_ready=0); release -> IDLE next edge.
4. Operand change after acceptance: a switched to 0xFFFF_FFFF during RUN -> result reflects the latched operands only.
5. Reset mid-RUN (after slice 2) -> out_valid=0, res=0, in_ready=1 after release; the next operation (a=1, b=2, XOR) yields res=3.
6. Parameter sweep WIDTH=32 with SLICE ∈ {1, 32}, WIDTH=16/SLICE=4: random ops vs reference model -> latency equals NSLICE, all results match.
